// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES tables, decrypt FSM encoding and GF(2^8) helpers
package aes_pkg;
  localparam int BLOCK_SIZE = 128;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} aes_dec_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] fn_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] fn_gf_multiply9(input logic [7:0] b);
    return fn_xtime(fn_xtime(fn_xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] fn_gf_multiply11(input logic [7:0] b);
    return fn_xtime(fn_xtime(fn_xtime(b))) ^ fn_xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] fn_gf_multiply13(input logic [7:0] b);
    return fn_xtime(fn_xtime(fn_xtime(b))) ^ fn_xtime(fn_xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] fn_gf_multiply14(input logic [7:0] b);
    return fn_xtime(fn_xtime(fn_xtime(b))) ^ fn_xtime(fn_xtime(b)) ^ fn_xtime(b);
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless skip_mix.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:BLOCK_SIZE-1] state,
  input  logic [0:BLOCK_SIZE-1] round_key,
  input  logic                  skip_mix,
  output logic [0:BLOCK_SIZE-1] next_state
);

  logic [0:BLOCK_SIZE-1] sub_key;
  logic [0:BLOCK_SIZE-1] mixed;

  function automatic logic [31:0] fn_inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {fn_gf_multiply14(a0) ^ fn_gf_multiply11(a1) ^ fn_gf_multiply13(a2) ^ fn_gf_multiply9(a3),
            fn_gf_multiply9(a0)  ^ fn_gf_multiply14(a1) ^ fn_gf_multiply11(a2) ^ fn_gf_multiply13(a3),
            fn_gf_multiply13(a0) ^ fn_gf_multiply9(a1)  ^ fn_gf_multiply14(a2) ^ fn_gf_multiply11(a3),
            fn_gf_multiply11(a0) ^ fn_gf_multiply13(a1) ^ fn_gf_multiply9(a2)  ^ fn_gf_multiply14(a3)};
  endfunction

  // Row r of output column c comes from input column (c - r) mod 4.
  always_comb begin
    sub_key = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_key[8*(4*c+r) +: 8] = INV_SBOX[state[8*(4*((c-r)&3)+r) +: 8]]
                                  ^ round_key[8*(4*c+r) +: 8];
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[32*c +: 32] = fn_inv_mix_col(sub_key[32*c +: 32]);
    end
  end

  assign next_state = skip_mix ? sub_key : mixed;

endmodule

// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - iterative AES-128 inverse cipher with valid/ready handshake
// AES_DEC_TWO_ROUNDS_EN: apply two inverse rounds per cycle (5-cycle latency).
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int NR      = 10,
  parameter int KS_BITS = (NR + 1) * 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:BLOCK_SIZE-1] in_data,
  input  logic [0:KS_BITS-1]    key_schedule,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:BLOCK_SIZE-1] out_data,
  output logic                  busy
);

  aes_dec_state_t        state_q, state_d;
  logic [3:0]            rnd;
  logic [0:BLOCK_SIZE-1] blk;
  logic [0:BLOCK_SIZE-1] round_out;
  logic [0:BLOCK_SIZE-1] rk_a;
  logic [0:BLOCK_SIZE-1] rk_last;
  logic                  last_round;

  assign rk_last = key_schedule[NR*BLOCK_SIZE +: BLOCK_SIZE];
  assign rk_a    = key_schedule[int'(rnd)*BLOCK_SIZE +: BLOCK_SIZE];

`ifdef AES_DEC_TWO_ROUNDS_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  logic [3:0]            rnd_b;
  logic [0:BLOCK_SIZE-1] rk_b;
  logic [0:BLOCK_SIZE-1] mid;

  // Clamp keeps the second key select in range while rnd is idle at 0.
  assign rnd_b      = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
  assign rk_b       = key_schedule[int'(rnd_b)*BLOCK_SIZE +: BLOCK_SIZE];
  assign last_round = (rnd <= 4'd1);

  aes_inv_round u_round_a (.state(blk), .round_key(rk_a), .skip_mix(rnd == 4'd0),   .next_state(mid));
  aes_inv_round u_round_b (.state(mid), .round_key(rk_b), .skip_mix(rnd_b == 4'd0), .next_state(round_out));
`else
  localparam logic [3:0] RND_STEP = 4'd1;

  assign last_round = (rnd == 4'd0);

  aes_inv_round u_round_a (.state(blk), .round_key(rk_a), .skip_mix(rnd == 4'd0), .next_state(round_out));
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)   state_d = ST_ROUND;
      ST_ROUND: if (last_round) state_d = ST_DONE;
      ST_DONE:  if (out_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rnd      <= 4'd0;
      blk      <= '0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) begin
          blk <= in_data ^ rk_last;
          rnd <= 4'(NR - 1);
        end
        ST_ROUND: if (last_round) begin
          out_data <= round_out;
          rnd      <= 4'd0;
        end else begin
          blk <= round_out;
          rnd <= rnd - RND_STEP;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb/tb_aes_decrypt_core.sv - self-checking bench for aes_decrypt_core
// Reference: forward AES-128 cipher and key expansion modelled byte-wise.
module tb_aes_decrypt_core;
  import aes_pkg::*;

`ifdef AES_DEC_TWO_ROUNDS_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 10;
`endif

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:127]   in_data, out_data;
  logic [0:1407]  key_schedule;
  logic [0:1407]  ks_c1, ks_b;
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  aes_decrypt_core dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key_schedule(key_schedule), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [0:1407] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [0:1407] ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk, res;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
    for (int rd = 0; rd <= 10; rd++) begin
      if (rd > 0) begin
        for (int k = 0; k < 16; k++) t[k] = SBOX[s[k]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
        if (rd < 10) begin
          for (int k = 0; k < 16; k++) t[k] = s[k];
          for (int c = 0; c < 4; c++) begin
            s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
            s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
            s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
            s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
          end
        end
      end
      rk = ks[rd*128 +: 128];
      for (int k = 0; k < 16; k++) s[k] ^= rk[127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Offer one block with out_ready high; checks latency, data and return to idle.
  task automatic do_block(input logic [127:0] ct, input logic [127:0] exp, input string tag);
    int n;
    in_data  = ct;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_out(n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_data"}, out_data, exp);
    @(posedge clk); #1;
    check({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int           n;
    logic         ok, seen;
    logic [127:0] key, pt, ct;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0;
    ks_c1 = expand_key(KEY_C1);
    ks_b  = expand_key(KEY_B);
    key_schedule = ks_c1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);

    do_block(CT_C1, PT_C1, "c1");
    key_schedule = ks_b;
    do_block(CT_B, PT_B, "fipsb");

    // Output backpressure with new blocks offered while DONE.
    key_schedule = ks_c1;
    out_ready = 1'b0;
    in_data = CT_C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(n);
    check("bp_lat", n, LAT);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      if (out_data !== PT_C1 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_hold", ok, 1);
    check("bp_data", out_data, PT_C1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);

    // Back-to-back with in_valid held high.
    key_schedule = ks_c1;
    in_data = CT_C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = CT_B;
    wait_out(n);
    check("b2b_lat1", n, LAT);
    check("b2b_data1", out_data, PT_C1);
    key_schedule = ks_b;
    @(posedge clk); #1;
    check("b2b_gap_ready", in_ready, 1);
    @(posedge clk); #1;
    check("b2b_second_accept", busy, 1);
    in_valid = 1'b0;
    wait_out(n);
    check("b2b_lat2", n, LAT);
    check("b2b_data2", out_data, PT_B);
    @(posedge clk); #1;
    check("b2b_idle", in_ready, 1);

    // Reset sampled at E5 of an in-flight block.
    key_schedule = ks_c1;
    in_data = CT_C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_emit", seen, 0);
    do_block(CT_C1, PT_C1, "post_rst");

    // Random round-trip against the forward-cipher model.
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key_schedule = expand_key(key);
      ct = encrypt(pt, key_schedule);
      do_block(ct, pt, "rt");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
